// File: rtl/core_seq_pkg.sv
// Shared types and constants for the RV32i multi-cycle control sequencer.
//   state_t    : sequencer phase encoding
//   NOP        : instruction register value after reset (addi x0, x0, 0)
//   WDOG_W     : width of the shared request wait counter
//   misaligned : true when a jump/branch target is not word aligned
package core_seq_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned WDOG_W = 8;

   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      EXEC,
      MEM,
      WB,
      FAULT
   } state_t;

   // Only the two low address bits decide word alignment.
   function automatic logic misaligned(input logic [1:0] addr_lo);
      return addr_lo != 2'b00;
   endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Request wait counter shared by the fetch and data-memory phases.
//   clk, reset : clock and synchronous active-high reset
//   clear      : force the count to zero (held while no request is pending)
//   enable     : count one more cycle spent waiting for an ack
//   done_c     : count has reached TIMEOUT
module seq_watchdog
   import core_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned W       = WDOG_W
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic done_c
);

   logic [W-1:0] count;

   // Wait counter; clear wins over enable.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + W'(1);
      end
   end

   assign done_c = (count == W'(TIMEOUT));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer for the RV32i core: fetches into the
// instruction register, steps EXEC / MEM / WB, gates decoder write enables
// to once per instruction, owns pc, instret and a sticky bus-timeout fault.
//   clk, reset            : clock, synchronous active-high reset
//   imem_req/addr/ack/rdata : instruction fetch port (addr == pc)
//   inst                  : instruction register feeding the decoder
//   dec_regWE/dmemWE/load/pcSEL, alu_out : decoder and ALU results
//   dmem_req/we/ack/rdata : data memory port
//   load_data             : captured load data for the writeback mux
//   pc, reg_we, retire, instret, fault : architectural state and status
module core_sequencer
   import core_seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   input  logic        dec_regWE,
   input  logic        dec_dmemWE,
   input  logic        dec_load,
   input  logic        dec_pcSEL,
   input  logic [31:0] alu_out,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] load_data,
   output logic [31:0] pc,
   output logic        reg_we,
   output logic        retire,
   output logic [31:0] instret,
   output logic        fault
);

   state_t state_q;
   state_t state_n;

   logic        imem_req_n;
   logic        dmem_req_n;
   logic        dmem_we_n;
   logic        reg_we_n;
   logic        retire_n;
   logic        fault_n;
   logic        target_bad;
   logic        wd_clear;
   logic        wd_enable;
   logic        wd_done;
   logic [31:0] pc_target;

   // One counter serves both request phases; it sits at zero elsewhere so it
   // always starts fresh on entry to FETCH or MEM.
   seq_watchdog #(
      .TIMEOUT (TIMEOUT),
      .W       (WDOG_W)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .clear  (wd_clear),
      .enable (wd_enable),
      .done_c (wd_done)
   );

   // Next state and next values of the registered outputs.
   always_comb begin
      state_n    = state_q;
      wd_clear   = 1'b1;
      wd_enable  = 1'b0;
      imem_req_n = 1'b0;
      dmem_req_n = 1'b0;
      dmem_we_n  = 1'b0;
      reg_we_n   = 1'b0;
      retire_n   = 1'b0;
      fault_n    = 1'b0;
      target_bad = dec_pcSEL && misaligned(alu_out[1:0]);

      case (state_q)
         IDLE: state_n = FETCH;

         // An ack on the cycle the count equals TIMEOUT is still accepted,
         // so a request may wait up to TIMEOUT cycles.
         FETCH: begin
            wd_clear = 1'b0;
            if (imem_ack) begin
               state_n = EXEC;
            end else if (wd_done) begin
               state_n = FAULT;
            end else begin
               wd_enable = 1'b1;
            end
         end

         EXEC: state_n = (dec_load || dec_dmemWE) ? MEM : WB;

         MEM: begin
            wd_clear = 1'b0;
            if (dmem_ack) begin
               state_n = WB;
            end else if (wd_done) begin
               state_n = FAULT;
            end else begin
               wd_enable = 1'b1;
            end
         end

         // retire already carries the alignment verdict taken on WB entry.
         WB: state_n = retire ? FETCH : FAULT;

         FAULT: state_n = FAULT;

         default: state_n = IDLE;
      endcase

      // Outputs are registered, so decode them from the state being entered.
      imem_req_n = (state_n == FETCH);
      dmem_req_n = (state_n == MEM);
      dmem_we_n  = (state_n == MEM) && dec_dmemWE;
      retire_n   = (state_n == WB) && !target_bad;
      reg_we_n   = (state_n == WB) && !target_bad && dec_regWE;
      fault_n    = (state_n == FAULT);
   end

   // State, registered outputs and architectural registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         imem_req  <= 1'b0;
         dmem_req  <= 1'b0;
         dmem_we   <= 1'b0;
         reg_we    <= 1'b0;
         retire    <= 1'b0;
         fault     <= 1'b0;
         inst      <= NOP;
         load_data <= '0;
         pc        <= RESET_PC;
         pc_target <= RESET_PC;
         instret   <= '0;
      end else begin
         state_q  <= state_n;
         imem_req <= imem_req_n;
         dmem_req <= dmem_req_n;
         dmem_we  <= dmem_we_n;
         reg_we   <= reg_we_n;
         retire   <= retire_n;
         fault    <= fault_n;

         if (state_q == FETCH && imem_ack) begin
            inst <= imem_rdata;
         end

         if (state_q == MEM && dmem_ack && dec_load) begin
            load_data <= dmem_rdata;
         end

         // Next pc is frozen on WB entry alongside the alignment verdict.
         if (state_n == WB) begin
            pc_target <= dec_pcSEL ? alu_out : 32'(pc + 32'd4);
         end

         if (state_q == WB && retire) begin
            pc      <= pc_target;
            instret <= 32'(instret + 32'd1);
         end
      end
   end

   assign imem_addr = pc;

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control sequencer for the RV32i core. It fetches each instruction over a req/ack instruction-memory port and holds it in an instruction register that feeds the combinational decoder. It then steps the datapath through execute, data-memory and writeback phases, gating the decoder's write enables so they take effect exactly once per instruction. It owns the PC, the retired-instruction counter and a bus-timeout fault.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- TIMEOUT, 255, max cycles a request may wait for ack before fault (1..255)

- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address, equals pc
- imem_ack  in  1  fetch complete, imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- inst  out  32  instruction register to decoder
- dec_regWE  in  1  decoder register-write enable
- dec_dmemWE  in  1  decoder store enable
- dec_load  in  1  decoder: current instruction is a load
- dec_pcSEL  in  1  decoder: take ALU target as next PC
- alu_out  in  32  ALU result (jump/branch target)
- dmem_req  out  1  data access request
- dmem_we  out  1  store qualifier, valid with dmem_req
- dmem_ack  in  1  data access complete
- dmem_rdata  in  32  load data
- load_data  out  32  captured load data for writeback mux
- pc  out  32  current PC
- reg_we  out  1  gated register-file write enable
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  32  retired-instruction count
- fault  out  1  sticky fault flag

## Operation
- States: IDLE, FETCH, EXEC, MEM, WB, FAULT. Reset -> IDLE.
- IDLE: all requests low; next cycle -> FETCH.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: inst<=imem_rdata, -> EXEC.
- EXEC: one settle cycle for decoder/ALU. If dec_load|dec_dmemWE -> MEM, else -> WB.
- MEM: dmem_req=1, dmem_we=dec_dmemWE. On dmem_ack: load_data<=dmem_rdata when dec_load, -> WB.
- WB: reg_we=dec_regWE, retire=1, instret<=instret+1 (wraps at 2^32).
  - PC update: if dec_pcSEL then pc<=alu_out, else pc<=pc+4 (mod 2^32).
  - Then -> FETCH.
- Misaligned target: dec_pcSEL=1 with alu_out[1:0]!=0 in WB -> FAULT instead. No retire, pc unchanged, reg_we=0.
- Timeout: 8-bit wait counter clears on entering FETCH/MEM and increments each cycle without ack. Counter==TIMEOUT without ack -> FAULT.
- FAULT: fault=1, all requests/enables low, no state change until reset.
- reg_we and dmem_req are never asserted outside WB and MEM respectively; a store writes memory exactly once.

## Timing
- Reset values: pc=RESET_PC, inst=32'h0000_0013 (NOP), load_data=0, instret=0, fault=0. imem_req, dmem_req, dmem_we, reg_we and retire are all 0.
- Reset has priority in any state, including mid-request. The request drops in the cycle after the reset edge, and a late ack is ignored.
- Requests are held stable (address, we) until ack. An ack while the matching req is low is ignored.
- Ack may arrive in the same cycle req first rises (zero-wait).
- Zero-wait latency: non-memory instruction 3 cycles (FETCH, EXEC, WB); load/store 4 cycles. Each wait cycle adds 1.
- First imem_req rises 2 cycles after reset deasserts (IDLE, then FETCH).
- pc, instret and retire update on the WB edge. The new pc appears on imem_addr in the following FETCH cycle.

## Structure
- Package core_seq_pkg: state enum (IDLE, FETCH, EXEC, MEM, WB, FAULT), NOP constant 32'h0000_0013, timeout counter width 8.
- Sub-module seq_watchdog: a clear/enable wait counter with a timeout compare output (done = count==TIMEOUT). Instantiated once and shared by FETCH and MEM.
- The decoder, ALU and memories stay external; this block contains no decode logic.

## Test plan
- Reset release, zero-wait imem returning ADDI -> imem_req rises cycle 2 at addr 0; reg_we pulse cycle 4; pc=4; instret=1.
- SW with dmem_ack delayed 3 cycles -> dmem_req/dmem_we held 4 cycles, single write; reg_we=0; retire after ack+1; total 7 cycles.
- LW returning 32'hDEAD_BEEF -> load_data=32'hDEAD_BEEF in WB; reg_we=1 for one cycle.
- JAL with dec_pcSEL=1, alu_out=32'h0000_0100 -> next imem_addr=0x100. Repeat with alu_out=0x102 -> fault=1, no retire, pc unchanged.
- imem_ack never asserted with TIMEOUT=4 -> fault rises after 4 wait cycles; imem_req drops; reset clears fault, pc=RESET_PC.
- Reset asserted during MEM wait, then ack arrives -> no write side effects; IDLE follows; instret=0.
